// File: rtl/alu_acc_seq_if.sv
// Issue/result bus between the instruction decoder and the accumulator ALU.
// The decoder side is the master; the ALU is the slave.
interface alu_acc_seq_if #(
    parameter int WIDTH = 8
);
    logic             op_valid;
    logic             op_ready;
    logic [3:0]       op;
    logic [WIDTH-1:0] in_b;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_hi;
    logic [3:0]       flags;
    logic             res_valid;

    modport master (
        output op_valid, op, in_b,
        input  op_ready, acc, acc_hi, flags, res_valid
    );

    modport slave (
        input  op_valid, op, in_b,
        output op_ready, acc, acc_hi, flags, res_valid
    );
endinterface

// File: rtl/alu_acc_seq.sv
// Clocked accumulator ALU with registered {N,Z,V,C} flags and an iterative
// shift-and-add unsigned multiplier; ops are issued over a valid/ready handshake.
module alu_acc_seq #(
    parameter int WIDTH  = 8,
    parameter bit MUL_EN = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    alu_acc_seq_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};
    localparam logic [CW-1:0]    ONE_C  = {{(CW-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_MULT = 1'b1
    } state_t;

    state_t           state_r;
    state_t           state_nx_s;
    logic [CW-1:0]    cnt_r;
    logic [WIDTH-1:0] acc_r;
    logic [WIDTH-1:0] acc_hi_r;
    logic [3:0]       flags_r;
    logic             res_valid_r;
    logic             op_ready_r;
    logic [WIDTH-1:0] mcand_r;
    logic [WIDTH-1:0] p_hi_r;
    logic [WIDTH-1:0] p_lo_r;

    logic             accept_s;
    logic             is_mul_s;
    logic             mul_last_s;
    logic [WIDTH:0]   sum_s;
    logic [WIDTH:0]   dif_s;
    logic [WIDTH-1:0] res_s;
    logic             wr_acc_s;
    logic             upd_zn_s;
    logic             c_nx_s;
    logic             v_nx_s;
    logic [WIDTH-1:0] acc_nx_s;
    logic [3:0]       flags_nx_s;
    logic [WIDTH:0]   mul_sum_s;
    logic [WIDTH-1:0] mul_hi_nx_s;
    logic [WIDTH-1:0] mul_lo_nx_s;
    logic [3:0]       mul_flags_s;

    assign accept_s   = bus.op_valid && op_ready_r;
    assign is_mul_s   = accept_s && MUL_EN && (bus.op == 4'b1111);
    assign mul_last_s = (state_r == ST_MULT) && (cnt_r == ONE_C);

    assign bus.op_ready  = op_ready_r;
    assign bus.acc       = acc_r;
    assign bus.acc_hi    = acc_hi_r;
    assign bus.flags     = flags_r;
    assign bus.res_valid = res_valid_r;

    // Single-cycle datapath: next accumulator and flags for the op on the bus.
    always_comb begin
        sum_s    = {1'b0, acc_r} + {1'b0, bus.in_b};
        dif_s    = {1'b0, acc_r} - {1'b0, bus.in_b};
        res_s    = acc_r;
        wr_acc_s = 1'b0;
        upd_zn_s = 1'b0;
        c_nx_s   = flags_r[0];
        v_nx_s   = flags_r[1];
        case (bus.op)
            4'b0001: begin
                res_s = bus.in_b; wr_acc_s = 1'b1; upd_zn_s = 1'b1;
            end
            4'b0010, 4'b0011: begin
                if (bus.op == 4'b0011) begin
                    sum_s = sum_s + {ZERO_W, flags_r[0]};
                end else begin
                    sum_s = sum_s;
                end
                res_s = sum_s[WIDTH-1:0]; wr_acc_s = 1'b1; upd_zn_s = 1'b1;
                c_nx_s = sum_s[WIDTH];
                v_nx_s = (acc_r[WIDTH-1] == bus.in_b[WIDTH-1]) &&
                         (sum_s[WIDTH-1] != acc_r[WIDTH-1]);
            end
            4'b0100, 4'b0101, 4'b1110: begin
                if (bus.op == 4'b0101) begin
                    dif_s = dif_s - {ZERO_W, flags_r[0]};
                end else begin
                    dif_s = dif_s;
                end
                // CMP shares SUB's flags but leaves the accumulator alone
                res_s = dif_s[WIDTH-1:0]; wr_acc_s = (bus.op != 4'b1110); upd_zn_s = 1'b1;
                c_nx_s = dif_s[WIDTH];
                v_nx_s = (acc_r[WIDTH-1] != bus.in_b[WIDTH-1]) &&
                         (dif_s[WIDTH-1] != acc_r[WIDTH-1]);
            end
            4'b0110: begin
                res_s = ~acc_r; wr_acc_s = 1'b1; upd_zn_s = 1'b1; c_nx_s = 1'b0; v_nx_s = 1'b0;
            end
            4'b0111: begin
                res_s = acc_r & bus.in_b; wr_acc_s = 1'b1; upd_zn_s = 1'b1; c_nx_s = 1'b0; v_nx_s = 1'b0;
            end
            4'b1000: begin
                res_s = acc_r | bus.in_b; wr_acc_s = 1'b1; upd_zn_s = 1'b1; c_nx_s = 1'b0; v_nx_s = 1'b0;
            end
            4'b1001: begin
                res_s = acc_r ^ bus.in_b; wr_acc_s = 1'b1; upd_zn_s = 1'b1; c_nx_s = 1'b0; v_nx_s = 1'b0;
            end
            4'b1010: begin
                res_s = {acc_r[WIDTH-2:0], 1'b0}; wr_acc_s = 1'b1; upd_zn_s = 1'b1;
                c_nx_s = acc_r[WIDTH-1]; v_nx_s = 1'b0;
            end
            4'b1011: begin
                res_s = {1'b0, acc_r[WIDTH-1:1]}; wr_acc_s = 1'b1; upd_zn_s = 1'b1;
                c_nx_s = acc_r[0]; v_nx_s = 1'b0;
            end
            4'b1100: begin
                res_s = {acc_r[WIDTH-2:0], flags_r[0]}; wr_acc_s = 1'b1; upd_zn_s = 1'b1;
                c_nx_s = acc_r[WIDTH-1]; v_nx_s = 1'b0;
            end
            4'b1101: begin
                res_s = {flags_r[0], acc_r[WIDTH-1:1]}; wr_acc_s = 1'b1; upd_zn_s = 1'b1;
                c_nx_s = acc_r[0]; v_nx_s = 1'b0;
            end
            default: begin
                res_s = acc_r;
            end
        endcase
        if (wr_acc_s) begin
            acc_nx_s = res_s;
        end else begin
            acc_nx_s = acc_r;
        end
        if (upd_zn_s) begin
            flags_nx_s = {res_s[WIDTH-1], (res_s == ZERO_W), v_nx_s, c_nx_s};
        end else begin
            flags_nx_s = {flags_r[3:2], v_nx_s, c_nx_s};
        end
    end

    // One multiply step: low half starts as the multiplier and shifts product bits in.
    always_comb begin
        if (p_lo_r[0]) begin
            mul_sum_s = {1'b0, p_hi_r} + {1'b0, mcand_r};
        end else begin
            mul_sum_s = {1'b0, p_hi_r};
        end
        mul_hi_nx_s = mul_sum_s[WIDTH:1];
        mul_lo_nx_s = {mul_sum_s[0], p_lo_r[WIDTH-1:1]};
        mul_flags_s = {mul_hi_nx_s[WIDTH-1], ({mul_hi_nx_s, mul_lo_nx_s} == {ZERO_W, ZERO_W}),
                       1'b0, (mul_hi_nx_s != ZERO_W)};
    end

    // FSM next-state decode.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (is_mul_s) begin
                    state_nx_s = ST_MULT;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_MULT: begin
                if (cnt_r == ONE_C) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_MULT;
                end
            end
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Architectural registers and multiplier working registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_r       <= ZERO_W;
            acc_hi_r    <= ZERO_W;
            flags_r     <= 4'b0000;
            res_valid_r <= 1'b0;
            op_ready_r  <= 1'b1;
            cnt_r       <= {CW{1'b0}};
            mcand_r     <= ZERO_W;
            p_hi_r      <= ZERO_W;
            p_lo_r      <= ZERO_W;
        end else begin
            res_valid_r <= 1'b0;
            if (state_r == ST_MULT) begin
                p_hi_r <= mul_hi_nx_s;
                p_lo_r <= mul_lo_nx_s;
                cnt_r  <= cnt_r - ONE_C;
                if (mul_last_s) begin
                    acc_r       <= mul_lo_nx_s;
                    acc_hi_r    <= mul_hi_nx_s;
                    flags_r     <= mul_flags_s;
                    res_valid_r <= 1'b1;
                    op_ready_r  <= 1'b1;
                end
            end else if (is_mul_s) begin
                mcand_r    <= bus.in_b;
                p_lo_r     <= acc_r;
                p_hi_r     <= ZERO_W;
                cnt_r      <= CW'(WIDTH);
                op_ready_r <= 1'b0;
            end else if (accept_s) begin
                acc_r       <= acc_nx_s;
                flags_r     <= flags_nx_s;
                res_valid_r <= 1'b1;
            end
        end
    end
endmodule
